// File: rtl/dac_tx_pkg.sv
// Shared types and constants for the SPI DAC transmitter.
// The LATCH state is only reached in builds with DACTX_LDAC_EN defined.
package dac_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    LATCH
  } tx_state_t;

  localparam int         FRAME_BITS      = 16;
  localparam logic [3:0] DAC_CFG_DEFAULT = 4'b0011;

  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [3:0] cfg,
                                                        input logic [7:0] smp);
    return {cfg, smp, 4'b0000};
  endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// Divider for the SPI bit timing: one-cycle tick every CLK_DIV enabled cycles.
// The count restarts from zero whenever the enable is low.
module sclk_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == 8'(CLK_DIV - 1)) begin
      tick  = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dac_spi_tx.sv
// 8-bit sample to 16-bit SPI DAC write frame, mode 0, with one-entry pending buffer.
// Define DACTX_LDAC_EN to add the ldac_n port and the LATCH state after each frame.
module dac_spi_tx
  import dac_tx_pkg::*;
#(
  parameter int         CLK_DIV = 4,
  parameter logic [3:0] DAC_CFG = DAC_CFG_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] sample,
  input  logic       overrun_clr,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  output logic       busy,
  output logic       overrun
`ifdef DACTX_LDAC_EN
  ,
  output logic       ldac_n
`endif
);

  tx_state_t             state_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [4:0]            bit_cnt_q;
  logic [7:0]            pend_data_q;
  logic                  pend_valid_q;
  logic                  sclk_q;
  logic                  cs_n_q;
  logic                  mosi_q;
  logic                  busy_q;
  logic                  overrun_q;
  logic                  tick;
  logic                  load;

  assign load = (state_q == IDLE) && pend_valid_q;

  sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q != IDLE),
    .tick (tick)
  );

  // A start coinciding with the load refills the just-emptied slot: no overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_data_q  <= '0;
      pend_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (start) begin
        pend_data_q  <= sample;
        pend_valid_q <= 1'b1;
      end else if (load) begin
        pend_valid_q <= 1'b0;
      end
      if (start && pend_valid_q && !load) overrun_q <= 1'b1;
      else if (overrun_clr)               overrun_q <= 1'b0;
    end
  end

`ifdef DACTX_LDAC_EN
  logic ldac_n_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef DACTX_LDAC_EN
      ldac_n_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_valid_q) begin
            shift_q   <= build_frame(DAC_CFG, pend_data_q);
            mosi_q    <= DAC_CFG[3];
            cs_n_q    <= 1'b0;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            sclk_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (sclk_q) begin
              // Falling edge: present the next bit unless the last one just went out.
              sclk_q    <= 1'b0;
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (bit_cnt_q != 5'(FRAME_BITS - 1)) begin
                shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
                mosi_q  <= shift_q[FRAME_BITS-2];
              end
            end else if (bit_cnt_q == 5'(FRAME_BITS)) begin
              cs_n_q  <= 1'b1;
              mosi_q  <= 1'b0;
              state_q <= HOLD;
            end else begin
              sclk_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (tick) begin
`ifdef DACTX_LDAC_EN
            ldac_n_q <= 1'b0;
            state_q  <= LATCH;
`else
            busy_q   <= 1'b0;
            state_q  <= IDLE;
`endif
          end
        end
`ifdef DACTX_LDAC_EN
        LATCH: begin
          if (tick) begin
            ldac_n_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sclk    = sclk_q;
  assign cs_n    = cs_n_q;
  assign mosi    = mosi_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;
`ifdef DACTX_LDAC_EN
  assign ldac_n  = ldac_n_q;
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Randomized bench for dac_spi_tx: a timestamp-level model predicts frames,
// frame start cycles, busy and overrun; a pin monitor decodes the SPI traffic.
module tb_dac_spi_tx;
  import dac_tx_pkg::*;

  localparam int D = 4;
`ifdef DACTX_LDAC_EN
  localparam int FL = 35 * D;
`else
  localparam int FL = 34 * D;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] sample = '0;
  logic       overrun_clr = 1'b0;
  logic       sclk, cs_n, mosi, busy, overrun;
`ifdef DACTX_LDAC_EN
  logic       ldac_n;
`endif

  dac_spi_tx #(.CLK_DIV(D), .DAC_CFG(DAC_CFG_DEFAULT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sample      (sample),
    .overrun_clr (overrun_clr),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .busy        (busy),
    .overrun     (overrun)
`ifdef DACTX_LDAC_EN
    ,
    .ldac_n      (ldac_n)
`endif
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;

  // Reference model: pending slot plus the cycle at which the transmitter is free again.
  bit          m_pv = 0;
  logic [7:0]  m_pd = '0;
  bit          m_ovr = 0;
  int          m_idle = 0;
  logic [15:0] exp_q[$];
  int          expf_q[$];

  // Pin monitor results.
  logic [15:0] got_q[$];
  int          fall_q[$];
  int          low_q[$];
  int          bits_q[$];
  int          bfall_q[$];
  int          loff_q[$];
  int          llen_q[$];
  logic        p_sclk = 0, p_cs = 1, p_mosi = 0, p_busy = 0, p_ldac = 1;
  logic [15:0] cur_frame = '0;
  int          cur_bits = 0, cs_fall_cyc = 0, cs_rise_cyc = 0, ldac_fall_cyc = 0;
  int          last_chg = 0, last_rise = -100000;
  int          stab_err = 0, trk_err = 0;

  task automatic tick(input bit st, input logic [7:0] smp, input bit clr);
    bit   ld;
    logic cur_ldac;
    start = st; sample = smp; overrun_clr = clr;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      m_pv = 0; m_ovr = 0; m_idle = 0;
    end else begin
      ld = m_pv && (cyc - 1 >= m_idle);
      if (ld) begin
        exp_q.push_back({DAC_CFG_DEFAULT, m_pd, 4'h0});
        expf_q.push_back(cyc);
        m_idle = cyc + FL;
      end
      if (st && m_pv && !ld) m_ovr = 1;
      else if (clr)          m_ovr = 0;
      if (st) begin m_pd = smp; m_pv = 1; end
      else if (ld) m_pv = 0;
    end
    #1;
`ifdef DACTX_LDAC_EN
    cur_ldac = ldac_n;
`else
    cur_ldac = 1'b1;
`endif
    if (cs_n == 0 && p_cs == 1) begin
      fall_q.push_back(cyc);
      cs_fall_cyc = cyc; cur_bits = 0; cur_frame = '0;
      last_chg = cyc; last_rise = -100000;
    end else if (cs_n == 0 && mosi !== p_mosi) begin
      last_chg = cyc;
      if (cyc - last_rise < D) stab_err++;
    end
    if (cs_n == 0 && sclk == 1 && p_sclk == 0) begin
      cur_frame = {cur_frame[14:0], mosi};
      cur_bits++;
      if (cyc - last_chg < D) stab_err++;
      if (cur_bits == 1 && cyc - cs_fall_cyc != D) stab_err++;
      last_rise = cyc;
    end
    if (cs_n == 1 && p_cs == 0) begin
      got_q.push_back(cur_frame);
      bits_q.push_back(cur_bits);
      low_q.push_back(cyc - cs_fall_cyc);
      cs_rise_cyc = cyc;
    end
    if (busy == 0 && p_busy == 1) bfall_q.push_back(cyc);
    if (cur_ldac == 0 && p_ldac == 1) begin
      loff_q.push_back(cyc - cs_rise_cyc);
      ldac_fall_cyc = cyc;
    end
    if (cur_ldac == 1 && p_ldac == 0) llen_q.push_back(cyc - ldac_fall_cyc);
    if (rst && (busy !== (cyc < m_idle) || overrun !== m_ovr)) trk_err++;
    if (cs_n == 1 && (sclk !== 1'b0 || mosi !== 1'b0)) trk_err++;
    p_sclk = sclk; p_cs = cs_n; p_mosi = mosi; p_busy = busy; p_ldac = cur_ldac;
  endtask

  task automatic clear_q();
    exp_q.delete(); expf_q.delete(); got_q.delete(); fall_q.delete(); low_q.delete();
    bits_q.delete(); bfall_q.delete(); loff_q.delete(); llen_q.delete();
    stab_err = 0; trk_err = 0;
  endtask

  task automatic drain(input int maxc, output bit timed_out);
    timed_out = 1;
    for (int i = 0; i < maxc; i++) begin
      if (!m_pv && cyc >= m_idle && cs_n === 1'b1 && busy === 1'b0) begin
        timed_out = 0;
        break;
      end
      tick(0, 8'h00, 0);
    end
  endtask

  // Number of disagreements between decoded frames and the model's predictions.
  function automatic int frame_diffs();
    int n = 0;
    if (got_q.size() != exp_q.size() || fall_q.size() != expf_q.size() ||
        low_q.size() != got_q.size() || bits_q.size() != got_q.size() ||
        bfall_q.size() != got_q.size() || fall_q.size() != got_q.size())
      return 1000;
    foreach (got_q[i]) begin
      if (got_q[i] !== exp_q[i])       n++;
      if (fall_q[i] != expf_q[i])      n++;
      if (low_q[i] != 33 * D)          n++;
      if (bits_q[i] != 16)             n++;
      if (bfall_q[i] != fall_q[i] + FL) n++;
    end
    return n;
  endfunction

  task automatic test_reset();
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) tick(0, 8'h00, 0);
    chk_cnt++; if (sclk !== 1'b0)    $display("FAIL reset_sclk: got %b want 0", sclk);       else pass_cnt++;
    chk_cnt++; if (cs_n !== 1'b1)    $display("FAIL reset_cs_n: got %b want 1", cs_n);       else pass_cnt++;
    chk_cnt++; if (mosi !== 1'b0)    $display("FAIL reset_mosi: got %b want 0", mosi);       else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0)    $display("FAIL reset_busy: got %b want 0", busy);       else pass_cnt++;
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else pass_cnt++;
`ifdef DACTX_LDAC_EN
    chk_cnt++; if (ldac_n !== 1'b1)  $display("FAIL reset_ldac_n: got %b want 1", ldac_n);   else pass_cnt++;
`endif
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick(0, 8'h00, 0);
    $display("test_reset: done");
  endtask

  task automatic test_single();
    int          t0, fall0, bdelta, low0;
    logic [15:0] f0;
    bit          to;
    clear_q();
    t0 = cyc;
    tick(1, 8'hA5, 0);
    drain(1000, to);
    f0     = (got_q.size() > 0) ? got_q[0] : 16'hxxxx;
    fall0  = (fall_q.size() > 0) ? fall_q[0] : -1;
    bdelta = (bfall_q.size() > 0 && fall_q.size() > 0) ? bfall_q[0] - fall_q[0] : -1;
    low0   = (low_q.size() > 0) ? low_q[0] : -1;
    chk_cnt++; if (to)                  $display("FAIL single_timeout: frame never completed"); else pass_cnt++;
    chk_cnt++; if (got_q.size() != 1)   $display("FAIL single_count: got %0d frames want 1", got_q.size()); else pass_cnt++;
    chk_cnt++; if (f0 !== 16'h3A50)     $display("FAIL single_frame: got %h want 3a50", f0); else pass_cnt++;
    chk_cnt++; if (fall0 != t0 + 2)     $display("FAIL single_latency: cs_n fell at %0d want %0d", fall0, t0 + 2); else pass_cnt++;
    chk_cnt++; if (low0 != 33 * D)      $display("FAIL single_cs_low: got %0d want %0d", low0, 33 * D); else pass_cnt++;
    chk_cnt++; if (bdelta != FL)        $display("FAIL single_busy_len: got %0d want %0d", bdelta, FL); else pass_cnt++;
    chk_cnt++; if (stab_err != 0)       $display("FAIL single_mosi_stable: got %0d violations want 0", stab_err); else pass_cnt++;
    chk_cnt++; if (trk_err != 0)        $display("FAIL single_tracking: got %0d errors want 0", trk_err); else pass_cnt++;
    $display("test_single: frame %h fall %0d", f0, fall0);
  endtask

  task automatic test_back_to_back();
    logic [7:0]  a, b;
    logic [15:0] f1;
    int          gap, nd;
    bit          to;
    clear_q();
    a = 8'($urandom); b = 8'($urandom);
    tick(1, a, 0);
    for (int i = 0; i < 60; i++) tick(0, 8'h00, 0);
    tick(1, b, 0);
    drain(1000, to);
    nd  = frame_diffs();
    f1  = (got_q.size() > 1) ? got_q[1] : 16'hxxxx;
    gap = (fall_q.size() > 1) ? fall_q[1] - fall_q[0] : -1;
    chk_cnt++; if (to)                    $display("FAIL b2b_timeout: frames never completed"); else pass_cnt++;
    chk_cnt++; if (nd != 0)               $display("FAIL b2b_model: got %0d diffs want 0", nd); else pass_cnt++;
    chk_cnt++; if (f1 !== {4'h3, b, 4'h0}) $display("FAIL b2b_second_frame: got %h want %h", f1, {4'h3, b, 4'h0}); else pass_cnt++;
    chk_cnt++; if (gap != FL + 1)         $display("FAIL b2b_gap: got %0d want %0d", gap, FL + 1); else pass_cnt++;
    chk_cnt++; if (overrun !== 1'b0)      $display("FAIL b2b_overrun: got %b want 0", overrun); else pass_cnt++;
    chk_cnt++; if (stab_err + trk_err != 0) $display("FAIL b2b_tracking: got %0d errors want 0", stab_err + trk_err); else pass_cnt++;
    $display("test_back_to_back: %h %h gap %0d", a, b, gap);
  endtask

  task automatic test_overrun();
    logic [7:0]  v1, v2, v3;
    logic [15:0] f1;
    int          nd;
    bit          to;
    clear_q();
    v1 = 8'($urandom); v2 = 8'($urandom); v3 = 8'($urandom);
    tick(1, v1, 0);
    for (int i = 0; i < 30; i++) tick(0, 8'h00, 0);
    tick(1, v2, 0);
    for (int i = 0; i < 20; i++) tick(0, 8'h00, 0);
    tick(1, v3, 0);
    drain(1000, to);
    nd = frame_diffs();
    f1 = (got_q.size() > 1) ? got_q[1] : 16'hxxxx;
    chk_cnt++; if (to)                      $display("FAIL ovr_timeout: frames never completed"); else pass_cnt++;
    chk_cnt++; if (nd != 0)                 $display("FAIL ovr_model: got %0d diffs want 0", nd); else pass_cnt++;
    chk_cnt++; if (f1 !== {4'h3, v3, 4'h0}) $display("FAIL ovr_second_frame: got %h want %h", f1, {4'h3, v3, 4'h0}); else pass_cnt++;
    for (int i = 0; i < 10; i++) tick(0, 8'h00, 0);
    chk_cnt++; if (overrun !== 1'b1)        $display("FAIL ovr_sticky: got %b want 1", overrun); else pass_cnt++;
    tick(0, 8'h00, 1);
    chk_cnt++; if (overrun !== 1'b0)        $display("FAIL ovr_clear: got %b want 0", overrun); else pass_cnt++;
    chk_cnt++; if (trk_err != 0)            $display("FAIL ovr_tracking: got %0d errors want 0", trk_err); else pass_cnt++;
    $display("test_overrun: %h %h %h", v1, v2, v3);
  endtask

  task automatic test_set_clear();
    bit to;
    clear_q();
    tick(1, 8'($urandom), 0);
    for (int i = 0; i < 20; i++) tick(0, 8'h00, 0);
    tick(1, 8'($urandom), 0);
    tick(1, 8'($urandom), 1);
    chk_cnt++; if (overrun !== 1'b1) $display("FAIL setclr_overrun: got %b want 1", overrun); else pass_cnt++;
    drain(1000, to);
    tick(0, 8'h00, 1);
    chk_cnt++; if (to || trk_err != 0) $display("FAIL setclr_tracking: timeout %0d errors %0d want 0", to, trk_err); else pass_cnt++;
    $display("test_set_clear: overrun %b", overrun);
  endtask

  task automatic test_random();
    int gap, nd;
    bit to;
    clear_q();
    for (int k = 0; k < 6; k++) begin
      gap = $urandom_range(FL + 40, FL - 20);
      tick(1, 8'($urandom), 0);
      for (int i = 1; i < gap; i++) tick(0, 8'h00, 0);
    end
    drain(1000, to);
    nd = frame_diffs();
    chk_cnt++; if (to)     $display("FAIL rand_timeout: frames never completed"); else pass_cnt++;
    chk_cnt++; if (nd != 0) $display("FAIL rand_model: got %0d diffs want 0", nd); else pass_cnt++;
    chk_cnt++; if (stab_err + trk_err != 0) $display("FAIL rand_tracking: got %0d errors want 0", stab_err + trk_err); else pass_cnt++;
    tick(0, 8'h00, 1);
    $display("test_random: %0d frames", got_q.size());
  endtask

  task automatic test_reset_mid();
    bit to = 1;
    clear_q();
    tick(1, 8'($urandom), 0);
    for (int i = 0; i < 400; i++) begin
      if (i == 5) tick(1, 8'($urandom), 0);
      else        tick(0, 8'h00, 0);
      if (cur_bits == 8 && cs_n == 0) begin to = 0; break; end
    end
    chk_cnt++; if (to) $display("FAIL rstmid_timeout: 8th rise never seen"); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    chk_cnt++; if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0)
      $display("FAIL rstmid_async: got cs_n %b sclk %b busy %b want 1 0 0", cs_n, sclk, busy); else pass_cnt++;
    for (int i = 0; i < 3; i++) tick(0, 8'h00, 0);
    rst = 1'b1;
    clear_q();
    for (int i = 0; i < 300; i++) tick(0, 8'h00, 0);
    chk_cnt++; if (fall_q.size() != 0) $display("FAIL rstmid_no_frame: got %0d frames want 0", fall_q.size()); else pass_cnt++;
    chk_cnt++; if (trk_err != 0)       $display("FAIL rstmid_tracking: got %0d errors want 0", trk_err); else pass_cnt++;
    $display("test_reset_mid: frames after release %0d", fall_q.size());
  endtask

`ifdef DACTX_LDAC_EN
  task automatic test_latch();
    int off0, len0;
    bit to;
    clear_q();
    tick(1, 8'($urandom), 0);
    drain(1000, to);
    off0 = (loff_q.size() > 0) ? loff_q[0] : -1;
    len0 = (llen_q.size() > 0) ? llen_q[0] : -1;
    chk_cnt++; if (off0 != D) $display("FAIL latch_offset: got %0d want %0d", off0, D); else pass_cnt++;
    chk_cnt++; if (len0 != D) $display("FAIL latch_len: got %0d want %0d", len0, D); else pass_cnt++;
    $display("test_latch: offset %0d length %0d", off0, len0);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_set_clear();
    test_random();
    test_reset_mid();
`ifdef DACTX_LDAC_EN
    test_latch();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serial transmitter that takes 8-bit samples from the wave fetchers (`voltageVal` qualified by the `start` strobe) and ships each one to an external 8-bit SPI DAC as a 16-bit write frame. It sits between the FM/wave generation path and the board DAC pins. A one-entry pending buffer decouples the sample strobe from the frame timing. If a sample arrives while one is already pending, the pending sample is overwritten and a sticky overrun flag is set.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per SCLK half-period; legal range 2..255.
- `DAC_CFG`, default 4'b0011: frame bits [15:12], meaning channel A, unbuffered, 1x gain, active.
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-low reset (0 = reset).
- `start`  in  1: one-cycle sample strobe; `sample` is valid in that cycle.
- `sample`  in  8: sample value, captured only when `start` = 1.
- `overrun_clr`  in  1: clears `overrun`.
- `sclk`  out  1: SPI clock, mode 0 (idles low, DAC samples on the rising edge).
- `cs_n`  out  1: DAC chip select, active low.
- `mosi`  out  1: serial data, MSB first.
- `busy`  out  1: high from the first frame cycle until the return to IDLE.
- `overrun`  out  1: sticky; set when a pending sample is overwritten.
- `ldac_n`  out  1: DAC latch strobe; present only with `DACTX_LDAC_EN`.

## Operation
- **Frame format**: {`DAC_CFG`[3:0], sample[7:0], 4'b0000}, 16 bits, shifted MSB first.
- **Pending buffer**: `pend_data`[7:0] plus `pend_valid`.
  - `start` with `pend_valid` = 0: write the buffer and set `pend_valid`.
  - `start` with `pend_valid` = 1: overwrite the buffer and set `overrun`.
- **Overrun flag**: `overrun_clr` clears it. If set and clear occur in the same cycle, set wins.
- **FSM states**: IDLE, SETUP, SHIFT, HOLD, LATCH (LATCH exists only with the macro).
- **IDLE**: when `pend_valid` = 1, load the shift register from the pending buffer, clear `pend_valid`, drive `cs_n` low and `mosi` = bit 15, then go to SETUP.
  - If `start` arrives in the same cycle as this load, the new sample refills the buffer and does not count as an overrun.
- **SETUP**: hold for `CLK_DIV` cycles, then go to SHIFT with `sclk` high.
- **SHIFT**: `sclk` toggles every `CLK_DIV` cycles.
  - On each falling edge, shift the next bit onto `mosi`.
  - After the 16th high phase, `sclk` falls and stays low for `CLK_DIV` cycles, then go to HOLD.
- **HOLD**: `cs_n` high and `mosi` 0 for `CLK_DIV` cycles, then go to LATCH (with the macro) or IDLE.
- **Back-to-back frames**: a sample pending on return to IDLE starts its frame on the next cycle. No sample is dropped unless an overrun occurs.
- **Reset mid-frame**: all outputs return to their reset values immediately and the pending buffer is discarded. The DAC ignores the partial frame because `cs_n` rises before the 16th edge.

## Timing
- **Reset values**: `sclk` 0, `cs_n` 1, `mosi` 0, `busy` 0, `overrun` 0, `ldac_n` 1. All outputs are registered.
- **Start latency**: `start` at cycle t with the FSM idle and the buffer empty gives `cs_n` = 0 and `busy` = 1 at t+2 (t+1 buffer write, t+2 load).
- **Frame length**, from `cs_n` falling to the return to IDLE:
  - 34·`CLK_DIV` cycles without the macro (136 at default).
  - 35·`CLK_DIV` cycles with it.
- **Rising edges**: the first `sclk` rise occurs `CLK_DIV` cycles after `cs_n` falls. `mosi` is stable for ≥ `CLK_DIV` cycles on both sides of every rising edge.
- **Sample rate limit**: the sustained `start` period must be ≥ frame length + 1 cycle. A shorter period eventually sets `overrun`.
- **Counters**: the divider counter is 8 bits and the bit counter 5 bits. Neither wraps within a frame.

## Configuration
- **Macro**: `DACTX_LDAC_EN`.
- **With the macro defined**:
  - The `ldac_n` port exists.
  - The LATCH state drives `ldac_n` low for `CLK_DIV` cycles after HOLD, so the DAC updates synchronously with the frame end.
  - `busy` stays high through LATCH.
- **Without the macro**: there is no `ldac_n` port and no LATCH state. The DAC board ties LDAC low, so the DAC updates on the `cs_n` rise.

## Structure
- **Package `dac_tx_pkg`**:
  - `tx_state_t` enum (IDLE, SETUP, SHIFT, HOLD, LATCH).
  - `FRAME_BITS` = 16.
  - `DAC_CFG_DEFAULT` = 4'b0011.
- **Sub-module `sclk_tick_gen`**: `CLK_DIV` counter that emits a one-cycle `tick`. It is enabled by the FSM and reset to 0 whenever it is disabled. The FSM in `dac_spi_tx` consumes `tick` for every phase transition.

## Test plan
- **Single frame**: reset, then `start` with `sample` = 8'hA5 → `mosi` shows 16'h3A50 on the `sclk` rising edges, `cs_n` is low for 33·4 cycles, `busy` falls 136 cycles after `cs_n` falls.
- **Back-to-back**:
  - Stimulus: `start` 8'h12, then `start` 8'h34 while the first frame is still shifting.
  - Required response: frames 16'h3120 then 16'h3340, the second `cs_n` falling one cycle after IDLE, `overrun` stays 0.
- **Overrun**:
  - Stimulus: three `start` pulses (8'h01, 8'h02, 8'h03) within one frame.
  - Required response: frames carry 8'h01 then 8'h03, and `overrun` = 1 until `overrun_clr` is asserted.
- **Simultaneous set/clear**: `overrun_clr` and an overrunning `start` in the same cycle → `overrun` = 1.
- **Reset mid-frame**: assert `rst` = 0 after the 8th `sclk` rise → `cs_n` goes high and `sclk` low asynchronously, and no frame follows after release.
- **LATCH timing** (with `DACTX_LDAC_EN`): `ldac_n` is low for exactly 4 cycles, starting 4 cycles after `cs_n` rises.
